spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
SPI master that initiates full-duplex, LSB-first transfers to one of several Slave peripherals. It generates SCLK from the system clock with a programmable divider and supports all four SPI modes. It drives MOSI and SCLK, drives one active-low select line, and captures MISO into a parallel receive word. It sits between the host logic and the SPI Slave instances on the bus.

Parameters:
DATA_WIDTH, 8, bits per transfer.
CLK_DIV, 2, SCLK half-period in Clock cycles; must be >= 1.
NUM_SLAVES, 2, number of Slave_Select lines; must be >= 1.

Ports:
Clock  in  1  system clock; all logic is on posedge.
Reset  in  1  asynchronous, active-low reset.
Start  in  1  request a transfer; sampled only in IDLE.
Mode  in  2  SPI mode; CPOL = Mode[1], CPHA = Mode[1]^Mode[0]; must be stable from 1 cycle before Start.
Slave_Index  in  max(1,$clog2(NUM_SLAVES))  target slave number.
Tx_Data  in  DATA_WIDTH  word to send; latched when Start is accepted.
MISO  in  1  serial data from the selected slave.
SCLK  out  1  serial clock.
MOSI  out  1  serial data to the slaves.
Slave_Select  out  NUM_SLAVES  active-low one-hot select.
Rx_Data  out  DATA_WIDTH  received word; updated only at transfer end.
Busy  out  1  high while a transfer is in progress.
Done  out  1  one-cycle pulse at transfer completion.

Behaviour:
- Reset (asserted low, at any time including mid-transfer): state=IDLE, SCLK=0, MOSI=0, Slave_Select=all 1s, Rx_Data=0, Busy=0, Done=0, counters=0. The aborted word is discarded.
- IDLE: SCLK is registered from Mode[1] every cycle; Slave_Select is all 1s.
- Start is accepted on edge T0 if state=IDLE and Slave_Index < NUM_SLAVES. An out-of-range index is ignored: no Busy and no Done.
- On acceptance: latch Mode, Tx_Data and Slave_Index; drive Slave_Select[idx]=0; set Busy=1; enter SETUP.
- Edge timing: H = CLK_DIV. SCLK toggles at T0 + H*k for k = 1 to 2*DATA_WIDTH. Odd k is the leading edge; even k is the trailing edge.
- Sampling edge: leading edge when CPHA=0 (modes 0 and 3); trailing edge when CPHA=1 (modes 1 and 2).
  - Mode 0 samples on the rising edge.
  - Mode 1 samples on the falling edge.
  - Mode 2 samples on the rising edge.
  - Mode 3 samples on the falling edge.
- CPHA=0:
  - MOSI = Tx_Data[0] is driven at T0.
  - Each leading edge samples MISO.
  - Each trailing edge except the last shifts MOSI to the next bit.
- CPHA=1:
  - MOSI is unchanged at T0.
  - Each leading edge drives the next bit, starting with bit 0.
  - Each trailing edge samples MISO.
- Bit order is LSB first on both lines. The receive shift is rx <= {MISO, rx[DATA_WIDTH-1:1]}.
- States: IDLE -> SETUP (H cycles) -> SHIFT (2*DATA_WIDTH half-periods) -> HOLD (H cycles, SCLK at CPOL) -> IDLE.
- Completion at T0 + (2*DATA_WIDTH+1)*H. In that same cycle:
  - Slave_Select returns to all 1s.
  - Busy=0.
  - Done=1 for one cycle.
  - Rx_Data = rx.
- A new Start is accepted no earlier than the cycle after Done, which guarantees at least 1 cycle of deselect.
- Start, Mode, Tx_Data and Slave_Index changes while Busy are ignored.
- MOSI holds its last bit after completion.
- Counters: the half-period counter is $clog2(CLK_DIV+1) bits and the edge counter is $clog2(2*DATA_WIDTH+1) bits. Neither counter wraps within a transfer.

Decomposition:
- Package spi_pkg:
  - spi_mode_t (2-bit).
  - spi_state_e {IDLE, SETUP, SHIFT, HOLD}.
  - Functions cpol(mode) and cpha(mode).
  - The Slave module also uses this package.
- Sub-module spi_clk_gen, instantiated once:
  - Divider producing lead_strobe and trail_strobe plus the registered SCLK level.
  - Controlled by run, cpol and CLK_DIV.

Test Plan:
- Mode 0, CLK_DIV=2, Tx=0xA5, MISO tied to MOSI -> MOSI bits 1,0,1,0,0,1,0,1 on rising edges; Done at T0+34; Rx_Data=0xA5; Slave_Select[0] low for exactly cycles T0..T0+33.
- Mode 1, Tx=0x0F, responder model returning 0x3C LSB first sampled on falling edges -> Rx_Data=0x3C; SCLK idle 0; first MOSI change on the first rising edge.
- Modes 2 and 3, Tx=0x81 -> SCLK idles 1 before and after the transfer; 16 toggles; sampling on rising edges for mode 2 and falling edges for mode 3; loopback Rx_Data=0x81.
- Start pulsed again mid-transfer with Tx=0xFF, plus Slave_Index=NUM_SLAVES while IDLE -> first transfer unaffected, exactly one Done; out-of-range request produces no Busy.
- Reset asserted low after 5 edges of a transfer -> asynchronous return to SCLK=0, Slave_Select all 1s, Busy=0, Rx_Data=0, no Done; next transfer with Tx=0x5A completes correctly.
- Back-to-back: Start held high with Slave_Index=1 -> second transfer begins the cycle after Done; Slave_Select[1] is high for at least 1 cycle between the two transfers.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the master and by the slave peripherals.
//   spi_mode_t  : 2-bit SPI mode word
//   spi_state_e : transfer sequencer states
//   cpol/cpha   : decode of the mode word into clock polarity and phase.
//                 Phase is Mode[1]^Mode[0], so modes 0 and 3 sample on the
//                 leading edge, while modes 1 and 2 sample on the trailing edge.
package spi_pkg;

    typedef logic [1:0] spi_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    function automatic logic cpol(input spi_mode_t mode);
        return mode[1];
    endfunction

    function automatic logic cpha(input spi_mode_t mode);
        return mode[1] ^ mode[0];
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider for the SPI master.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   run          : high for the whole transfer (SETUP through HOLD)
//   cpol         : idle level; SCLK follows it every cycle while run is low
//   sclk         : registered serial clock
//   lead_strobe  : one cycle wide; the next clk edge is a leading SCLK edge
//   trail_strobe : one cycle wide; the next clk edge is a trailing SCLK edge
//   last_trail   : trail_strobe for the final SCLK edge of the word
//   end_strobe   : one cycle wide; the next clk edge ends the HOLD period
// Ticks occur every CLK_DIV cycles after run rises. Ticks 1..2*DATA_WIDTH
// toggle SCLK, and tick 2*DATA_WIDTH+1 closes the transfer.
module spi_clk_gen #(
    parameter int CLK_DIV    = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic cpol,
    output logic sclk,
    output logic lead_strobe,
    output logic trail_strobe,
    output logic last_trail,
    output logic end_strobe
);

    localparam int HP_W      = $clog2(CLK_DIV + 1);
    localparam int NUM_EDGES = 2 * DATA_WIDTH;
    localparam int EC_W      = $clog2(NUM_EDGES + 1);

    logic [HP_W-1:0] hp_cnt_reg;
    logic [EC_W-1:0] edge_cnt_reg;
    logic            sclk_reg;
    logic            tick;
    logic            in_shift;

    // edge_cnt_reg holds the number of ticks already taken, so an even count
    // means the coming tick is an odd (leading) edge.
    assign tick         = run && (hp_cnt_reg == HP_W'(CLK_DIV - 1));
    assign in_shift     = (edge_cnt_reg < EC_W'(NUM_EDGES));
    assign lead_strobe  = tick && in_shift && !edge_cnt_reg[0];
    assign trail_strobe = tick && in_shift && edge_cnt_reg[0];
    assign last_trail   = trail_strobe && (edge_cnt_reg == EC_W'(NUM_EDGES - 1));
    assign end_strobe   = tick && (edge_cnt_reg == EC_W'(NUM_EDGES));
    assign sclk         = sclk_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_cnt_reg   <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
        end else if (!run) begin
            hp_cnt_reg   <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= cpol;
        end else begin
            if (tick) begin
                hp_cnt_reg <= '0;
                // Clear rather than count past the final tick so the
                // counter never wraps.
                if (end_strobe) begin
                    edge_cnt_reg <= '0;
                end else begin
                    edge_cnt_reg <= edge_cnt_reg + EC_W'(1);
                end
            end else begin
                hp_cnt_reg <= hp_cnt_reg + HP_W'(1);
            end
            if (lead_strobe || trail_strobe) begin
                sclk_reg <= ~sclk_reg;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master: full-duplex, LSB-first transfers in any of the four SPI modes.
//   Clock        : system clock
//   Reset        : asynchronous active-low reset
//   Start        : transfer request, honoured only in IDLE with a valid index
//   Mode         : SPI mode (held stable from one cycle before Start)
//   Slave_Index  : target slave number
//   Tx_Data      : word to send, latched on acceptance
//   MISO         : serial input from the selected slave
//   SCLK, MOSI   : serial clock and data out
//   Slave_Select : active-low one-hot select
//   Rx_Data      : received word, updated only when a transfer completes
//   Busy         : high from acceptance until completion
//   Done         : one-cycle completion pulse
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int NUM_SLAVES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            Mode,
    input  logic [((NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1)-1:0] Slave_Index,
    input  logic [DATA_WIDTH-1:0] Tx_Data,
    input  logic                  MISO,
    output logic                  SCLK,
    output logic                  MOSI,
    output logic [NUM_SLAVES-1:0] Slave_Select,
    output logic [DATA_WIDTH-1:0] Rx_Data,
    output logic                  Busy,
    output logic                  Done
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    spi_state_e            state_reg, state_next;
    spi_mode_t             mode_reg;
    logic [DATA_WIDTH-1:0] tx_shift_reg;
    logic [DATA_WIDTH-1:0] rx_shift_reg;
    logic [DATA_WIDTH-1:0] rx_data_reg;
    logic                  mosi_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic accept;
    logic complete;
    logic run;
    logic gen_cpol;
    logic phase;
    logic lead_strobe;
    logic trail_strobe;
    logic last_trail;
    logic end_strobe;
    logic sample_strobe;
    logic shift_strobe;

    assign accept   = Start && (state_reg == IDLE) && (int'(Slave_Index) < NUM_SLAVES);
    assign run      = (state_reg != IDLE);
    assign complete = (state_reg == HOLD) && end_strobe;
    assign phase    = cpha(mode_reg);
    // While idle, SCLK tracks the live Mode so it already sits at the right
    // polarity when Start arrives.
    assign gen_cpol = run ? cpol(mode_reg) : Mode[1];

    // Phase 0 presents bit 0 at select time and moves on at trailing edges
    // (except the last, so MOSI holds bit DATA_WIDTH-1 afterwards). Phase 1
    // presents each bit at a leading edge.
    assign sample_strobe = phase ? trail_strobe : lead_strobe;
    assign shift_strobe  = phase ? lead_strobe  : (trail_strobe && !last_trail);

    spi_clk_gen #(
        .CLK_DIV    (CLK_DIV),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_clk_gen (
        .clk          (Clock),
        .rst_n        (Reset),
        .run          (run),
        .cpol         (gen_cpol),
        .sclk         (SCLK),
        .lead_strobe  (lead_strobe),
        .trail_strobe (trail_strobe),
        .last_trail   (last_trail),
        .end_strobe   (end_strobe)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)     state_next = SETUP;
            SETUP:   if (lead_strobe) state_next = SHIFT;
            SHIFT:   if (last_trail) state_next = HOLD;
            HOLD:    if (end_strobe) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= IDLE;
            mode_reg     <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            if (accept) begin
                mode_reg     <= Mode;
                tx_shift_reg <= Tx_Data;
                rx_shift_reg <= '0;
                busy_reg     <= 1'b1;
                if (!cpha(Mode)) begin
                    mosi_reg <= Tx_Data[0];
                end
            end else begin
                if (shift_strobe) begin
                    mosi_reg     <= phase ? tx_shift_reg[0] : tx_shift_reg[1];
                    tx_shift_reg <= tx_shift_reg >> 1;
                end
                if (sample_strobe) begin
                    rx_shift_reg <= {MISO, rx_shift_reg[DATA_WIDTH-1:1]};
                end
                if (complete) begin
                    busy_reg    <= 1'b0;
                    done_reg    <= 1'b1;
                    rx_data_reg <= rx_shift_reg;
                end
            end
        end
    end

    // One flop per select line, so the selects come straight from registers
    // and cannot glitch.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            logic sel_n_reg;
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    sel_n_reg <= 1'b1;
                end else if (accept) begin
                    sel_n_reg <= (Slave_Index != IDX_W'(gi));
                end else if (complete) begin
                    sel_n_reg <= 1'b1;
                end
            end
            assign Slave_Select[gi] = sel_n_reg;
        end
    endgenerate

    assign MOSI    = mosi_reg;
    assign Rx_Data = rx_data_reg;
    assign Busy    = busy_reg;
    assign Done    = done_reg;

endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master (3 slaves, CLK_DIV=2, 8 bits).
// The reference is a cycle-level observer of SCLK.
// A responder presents the next bit of its word after every sampling edge.
// The bench takes the sampling-edge direction per mode from a table.
module tb_spi_master;

    localparam int DW       = 8;
    localparam int CD       = 2;
    localparam int NS       = 3;
    localparam int IW       = 2;
    localparam int XFER_CYC = (2 * DW + 1) * CD;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [IW-1:0] sidx;
    logic [DW-1:0] tx_data;
    logic          miso;
    logic          sclk;
    logic          mosi;
    logic [NS-1:0] ss;
    logic [DW-1:0] rx_data;
    logic          busy;
    logic          done;

    bit   loopback;
    logic miso_resp;

    int n_vec        = 0;
    int n_miscompare = 0;

    assign miso = loopback ? mosi : miso_resp;

    spi_master #(
        .DATA_WIDTH (DW),
        .CLK_DIV    (CD),
        .NUM_SLAVES (NS)
    ) dut (
        .Clock        (clk),
        .Reset        (rst_n),
        .Start        (start),
        .Mode         (mode),
        .Slave_Index  (sidx),
        .Tx_Data      (tx_data),
        .MISO         (miso),
        .SCLK         (sclk),
        .MOSI         (mosi),
        .Slave_Select (ss),
        .Rx_Data      (rx_data),
        .Busy         (busy),
        .Done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer. hold_start leaves Start high after Done so the next call
    // (with b2b set) is accepted on the very next edge.
    task automatic xfer(input logic [1:0] m, input int idx, input logic [DW-1:0] tx,
                        input logic [DW-1:0] resp, input bit lb, input bit hold_start,
                        input bit b2b, input bit mid_start, input int abort_edges);
        logic          sample_rising;
        logic          idle_lvl;
        logic          prev_sclk;
        logic [DW-1:0] mosi_seen;
        logic [DW-1:0] rx0;
        logic [NS-1:0] exp_ss;
        int            n_samp;
        int            n_edges;
        int            done_cyc;
        int            ss_low_cyc;
        bit            busy_ok;
        bit            rx_ok;
        bit            aborted;
        bit            bad;

        // Modes 0 and 2 sample on rising SCLK, modes 1 and 3 on falling.
        sample_rising = (m == 2'd0) || (m == 2'd2);
        idle_lvl      = (m >= 2'd2);
        exp_ss        = '1;
        exp_ss[idx]   = 1'b0;
        mosi_seen     = '0;
        n_samp        = 0;
        n_edges       = 0;
        done_cyc      = -1;
        ss_low_cyc    = 0;
        busy_ok       = 1'b1;
        rx_ok         = 1'b1;
        aborted       = 1'b0;
        loopback      = lb;
        miso_resp     = resp[0];
        mode          = m;
        if (!b2b) begin
            @(posedge clk); #1;
            check_value("idle_sclk", sclk, idle_lvl);
        end
        start   = 1'b1;
        tx_data = tx;
        sidx    = IW'(idx);
        prev_sclk = idle_lvl;
        for (int c = 0; c < XFER_CYC + 20; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                if (!hold_start) start = 1'b0;
                rx0 = rx_data;
                check_value("busy_t0", busy, 1);
                check_value("ss_t0", ss, exp_ss);
                // Modes 0 and 3 present bit 0 as soon as the slave is selected.
                if (m == 2'd0 || m == 2'd3) check_value("mosi_t0", mosi, tx[0]);
            end
            if (mid_start && c == 10) begin
                start   = 1'b1;
                tx_data = 8'hFF;
            end
            if (mid_start && c == 12) start = 1'b0;
            if (sclk !== prev_sclk) begin
                n_edges++;
                if (sclk == sample_rising) begin
                    if (n_samp < DW) mosi_seen[n_samp] = mosi;
                    n_samp++;
                    if (n_samp < DW) miso_resp = resp[n_samp];
                end
                prev_sclk = sclk;
            end
            if (ss === exp_ss) ss_low_cyc++;
            if (done) begin
                done_cyc = c;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (rx_data !== rx0) rx_ok = 1'b0;
            end
            if (abort_edges > 0 && n_edges == abort_edges) begin
                #2 rst_n = 1'b0;
                #1;
                check_value("rst_sclk", sclk, 0);
                check_value("rst_ss", ss, {NS{1'b1}});
                check_value("rst_busy", busy, 0);
                check_value("rst_rx", rx_data, 0);
                check_value("rst_done", done, 0);
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                bad = 1'b0;
                repeat (XFER_CYC + 5) begin
                    @(posedge clk); #1;
                    if (done || busy) bad = 1'b1;
                end
                check_value("rst_no_done", bad, 0);
                $display("xfer mode=%0d idx=%0d tx=%02h aborted by reset after %0d edges", m, idx, tx, n_edges);
                aborted = 1'b1;
                break;
            end
            if (done_cyc >= 0) break;
        end
        if (aborted) return;
        check_value("done_cyc", done_cyc, XFER_CYC);
        check_value("rx_data", rx_data, lb ? tx : resp);
        check_value("mosi_bits", mosi_seen, tx);
        check_value("sclk_edges", n_edges, 2 * DW);
        check_value("ss_low_cyc", ss_low_cyc, XFER_CYC);
        check_value("busy_held", busy_ok, 1);
        check_value("rx_stable", rx_ok, 1);
        check_value("ss_done", ss, {NS{1'b1}});
        check_value("busy_done", busy, 0);
        check_value("sclk_end", sclk, idle_lvl);
        $display("xfer mode=%0d idx=%0d tx=%02h rx=%02h done_at=%0d", m, idx, tx, rx_data, done_cyc);
        if (!hold_start) begin
            bad = 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                if (done || busy) bad = 1'b1;
            end
            check_value("quiet_after", bad, 0);
        end
    endtask

    task automatic out_of_range();
        bit bad;
        mode = 2'd0;
        @(posedge clk); #1;
        start   = 1'b1;
        sidx    = IW'(NS);
        tx_data = 8'h77;
        @(posedge clk); #1;
        start = 1'b0;
        bad   = 1'b0;
        repeat (XFER_CYC + 4) begin
            if (busy || done || ss !== {NS{1'b1}}) bad = 1'b1;
            @(posedge clk); #1;
        end
        check_value("oor_ignored", bad, 0);
        $display("xfer idx=%0d out of range, ignored", NS);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 2'd0;
        sidx      = '0;
        tx_data   = '0;
        loopback  = 1'b0;
        miso_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_sclk", sclk, 0);
        check_value("reset_mosi", mosi, 0);
        check_value("reset_ss", ss, {NS{1'b1}});
        check_value("reset_busy", busy, 0);
        check_value("reset_done", done, 0);
        check_value("reset_rx", rx_data, 0);
        rst_n = 1'b1;

        // m, idx, tx, resp, lb, hold, b2b, mid, abort
        xfer(2'd0, 0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        xfer(2'd1, 2, 8'h0F, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        xfer(2'd2, 1, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        xfer(2'd3, 0, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        xfer(2'd0, 1, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        out_of_range();
        xfer(2'd1, 2, 8'hC3, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        xfer(2'd0, 0, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        xfer(2'd3, 1, 8'h6E, 8'hB1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        xfer(2'd3, 1, 8'h29, 8'h4D, 1'b0, 1'b0, 1'b1, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            xfer(2'($urandom_range(0, 3)), int'($urandom_range(0, NS - 1)),
                 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'b0, 1'b0, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
